// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, state encoding and fault rule for the instruction-fetch front end.
package pc_fetch_unit_pkg;

  localparam int unsigned IMEM_BYTES_DEFAULT = 1024;
  localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // A fetch is illegal when it leaves the memory or is not word aligned.
  function automatic logic pc_fault(input logic [63:0] pc, input int unsigned imem_bytes);
    return (pc >= 64'(imem_bytes)) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, program-load and IF/ID signals between the fetch unit and its neighbours.
interface pc_fetch_unit_if;

  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [31:0] ld_data;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [63:0] fetch_pc;
  logic        imem_error;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, ld_en, ld_addr, ld_data,
    input  if_pc, if_instr, if_valid, fetch_pc, imem_error, halted, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, ld_en, ld_addr, ld_data,
    output if_pc, if_instr, if_valid, fetch_pc, imem_error, halted, fetch_count
  );

endinterface

// File: rtl/pc_fetch_unit_imem_array.sv
// Instruction word store: asynchronous read, synchronous write, contents never cleared.
module pc_fetch_unit_imem_array #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read sees the pre-write word when both target the same entry in one cycle.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: architectural PC, IF/ID register, sticky fault/halt and delivered-instruction counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  bus
);

  localparam int unsigned DEPTH = IMEM_BYTES / 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d;
  logic         imem_error_q, imem_error_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;
  logic [1:0]    unused_ld_bits;

  // Out-of-range loads are dropped here so they cannot alias onto a valid word.
  assign wr_en          = bus.ld_en && (bus.ld_addr < 64'(IMEM_BYTES));
  assign wr_idx         = bus.ld_addr[AW+1:2];
  assign rd_idx         = pc_q[AW+1:2];
  assign unused_ld_bits = bus.ld_addr[1:0];

  pc_fetch_unit_imem_array #(
    .DEPTH (DEPTH)
  ) u_imem_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (bus.ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    imem_error_d  = imem_error_q;
    fetch_count_d = fetch_count_q;

    // HALT keeps every register as is; only reset leaves it.
    if (state_q == ST_RUN) begin
      if (bus.branch_taken) begin
        pc_d       = bus.branch_target;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end else if (pc_fault(pc_q, IMEM_BYTES)) begin
        state_d      = ST_HALT;
        imem_error_d = 1'b1;
        if_instr_d   = NOP_INSTR;
        if_valid_d   = 1'b0;
      end else if (!bus.stall) begin
        if_pc_d       = pc_q;
        if_instr_d    = rd_data;
        if_valid_d    = 1'b1;
        pc_d          = pc_q + 64'd4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_pc_q       <= 64'h0;
      if_instr_q    <= NOP_INSTR;
      if_valid_q    <= 1'b0;
      imem_error_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      imem_error_q  <= imem_error_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.if_pc       = if_pc_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_pc    = pc_q;
  assign bus.imem_error  = imem_error_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic, each cycle checked against a behavioural fetch model.
module tb_pc_fetch_unit;

  localparam longint unsigned IMEM = 1024;
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(
    .IMEM_BYTES (1024),
    .RESET_PC   (64'h0),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Behavioural model state
  logic [31:0]     mem_m [256];
  longint unsigned m_pc;
  longint unsigned m_if_pc;
  logic [31:0]     m_instr;
  logic            m_valid;
  logic            m_err;
  logic            m_halt;
  logic [31:0]     m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (step %0d)", tag, obs, exp, step_no);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic bt, input logic [63:0] tgt,
                       input logic le, input logic [63:0] la, input logic [31:0] ldat);
    reset             = r;
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.ld_en         = le;
    bus.ld_addr       = la;
    bus.ld_data       = ldat;
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = 0; m_if_pc = 0; m_instr = NOP; m_valid = 0; m_err = 0; m_halt = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (bus.branch_taken) begin
        m_pc = bus.branch_target; m_instr = NOP; m_valid = 0;
      end else if (m_pc >= IMEM || (m_pc % 4) != 0) begin
        m_halt = 1; m_err = 1; m_instr = NOP; m_valid = 0;
      end else if (!bus.stall) begin
        m_if_pc = m_pc;
        m_instr = mem_m[m_pc / 4];
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_cnt   = m_cnt + 1;
      end
    end
    // Write lands after the fetch, so a same-cycle fetch sees the old word.
    if (bus.ld_en && bus.ld_addr < IMEM) mem_m[bus.ld_addr / 4] = bus.ld_data;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    step_no++;
    $display("step %0d rst=%b st=%b bt=%b fetch_pc=%h if_pc=%h instr=%h v=%b err=%b halt=%b cnt=%0d",
             step_no, reset, bus.stall, bus.branch_taken, bus.fetch_pc, bus.if_pc, bus.if_instr,
             bus.if_valid, bus.imem_error, bus.halted, bus.fetch_count);
    chk("fetch_pc",    bus.fetch_pc,           m_pc);
    chk("if_pc",       bus.if_pc,              m_if_pc);
    chk("if_instr",    64'(bus.if_instr),      64'(m_instr));
    chk("if_valid",    64'(bus.if_valid),      64'(m_valid));
    chk("imem_error",  64'(bus.imem_error),    64'(m_err));
    chk("halted",      64'(bus.halted),        64'(m_halt));
    chk("fetch_count", 64'(bus.fetch_count),   64'(m_cnt));
  endtask

  initial begin
    logic [31:0] w;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    m_pc = 0; m_if_pc = 0; m_instr = NOP; m_valid = 0; m_err = 0; m_halt = 0; m_cnt = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;

    // Program load while held in reset; every word is defined before any fetch.
    for (int i = 0; i < 256; i++) begin
      w = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 : $urandom;
      drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'(i * 4), w);
      step();
    end
    chk("reset_if_valid", 64'(bus.if_valid), 64'h0);
    chk("reset_if_instr", 64'(bus.if_instr), 64'(NOP));

    // Scenario 1: two sequential fetches
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t1_if_pc0",  bus.if_pc, 64'h0);
    chk("t1_instr0",  64'(bus.if_instr), 64'h0050_0093);
    chk("t1_valid0",  64'(bus.if_valid), 64'h1);
    step();
    chk("t1_if_pc1",  bus.if_pc, 64'h4);
    chk("t1_instr1",  64'(bus.if_instr), 64'h00A0_0113);
    chk("t1_count",   64'(bus.fetch_count), 64'd2);

    // Scenario 2: three-cycle stall at fetch_pc 8
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
      step();
      chk("t2_hold_pc", bus.fetch_pc, 64'h8);
      chk("t2_hold_if", bus.if_pc, 64'h4);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t2_if_pc8", bus.if_pc, 64'h8);
    chk("t2_instr8", 64'(bus.if_instr), 64'(mem_m[2]));

    // Scenario 3: redirect wins over stall
    drive(1'b0, 1'b1, 1'b1, 64'h40, 1'b0, 64'h0, 32'h0);
    step();
    chk("t3_pc40",   bus.fetch_pc, 64'h40);
    chk("t3_bubble", 64'(bus.if_instr), 64'(NOP));
    chk("t3_valid",  64'(bus.if_valid), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t3_if_pc40", bus.if_pc, 64'h40);

    // Scenario 6: same-cycle load and fetch of word 0; out-of-range load dropped
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 32'hDEAD_BEEF);
    step();
    chk("t6_old_word", 64'(bus.if_instr), 64'h0050_0093);
    drive(1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 64'd1024, 32'h1111_1111);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t6_new_word", 64'(bus.if_instr), 64'hDEAD_BEEF);

    // Scenario 5: misaligned redirect halts on the following cycle
    drive(1'b0, 1'b0, 1'b1, 64'h42, 1'b0, 64'h0, 32'h0);
    step();
    chk("t5_pc42", bus.fetch_pc, 64'h42);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t5_halted", 64'(bus.halted), 64'h1);
    chk("t5_err",    64'(bus.imem_error), 64'h1);

    // Scenario 4: run off the end of memory, redirect ignored in HALT, reset clears
    drive(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 64'h3F8, 1'b0, 64'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    step();
    chk("t4_pc_end", bus.fetch_pc, 64'h400);
    chk("t4_last_if_pc", bus.if_pc, 64'h3FC);
    step();
    chk("t4_halted", 64'(bus.halted), 64'h1);
    chk("t4_err",    64'(bus.imem_error), 64'h1);
    chk("t4_valid",  64'(bus.if_valid), 64'h0);
    drive(1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t4_bt_ignored", bus.fetch_pc, 64'h400);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("t4_rst_halt",  64'(bus.halted), 64'h0);
    chk("t4_rst_err",   64'(bus.imem_error), 64'h0);
    chk("t4_rst_count", 64'(bus.fetch_count), 64'h0);
    chk("t4_rst_pc",    bus.fetch_pc, 64'h0);

    // Top-of-address-space redirect faults immediately
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step();
    chk("wrap_halted", 64'(bus.halted), 64'h1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic        r, st, bt, le;
      logic [63:0] tgt, la;
      r   = ($urandom_range(99) < 2);
      st  = ($urandom_range(99) < 25);
      bt  = ($urandom_range(99) < 10);
      le  = ($urandom_range(99) < 20);
      tgt = ($urandom_range(19) == 0) ? 64'($urandom_range(2047)) : 64'($urandom_range(255) * 4);
      la  = 64'($urandom_range(2047));
      drive(r, st, bt, tgt, le, la, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
